// File: rtl/usb_tx_encoder.sv
// ---------------------------------------------------------------------------
// usb_tx_encoder
//
// Full-speed USB transmit line encoder. Accepts packet bytes over a
// valid/ready handshake, prepends SYNC (0x80), serializes LSB first, inserts
// a stuffed 0 after six consecutive 1s, NRZI-encodes the stream and appends
// EOP (SE0, SE0, J). The line outputs and status pulses are registered.
//
// Parameters:
//   CLKS_PER_BIT   clock cycles per USB bit time (>= 2)
//
// Ports:
//   clk            rising-edge clock
//   n_rst          synchronous active-low reset
//   tx_start       one-cycle packet request, honoured only when idle
//   tx_data        next packet byte
//   tx_data_valid  tx_data is valid
//   tx_last        tx_data is the final byte of the packet
//   tx_data_ready  byte-fetch strobe (transfer when ready & valid)
//   d_plus_out     encoded D+
//   d_minus_out    encoded D-
//   tx_active      pad drive enable
//   tx_done        one-cycle pulse as the packet completes
//   tx_error       one-cycle pulse after an underrun
// ---------------------------------------------------------------------------
module usb_tx_encoder #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_last,
    output logic       tx_data_ready,
    output logic       d_plus_out,
    output logic       d_minus_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
    localparam logic [7:0] SyncPattern = 8'h80;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
        StEopSe0,
        StEopJ
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;      // clock cycle within the current bit time
    logic [2:0]      idx_q, idx_d;      // bit index in SYNC/byte, or SE0 bit count
    logic [2:0]      ones_q, ones_d;    // consecutive raw 1s, including the bit on the line
    logic [7:0]      shift_q, shift_d;  // bit on the line is shift_q[0]
    logic            last_q, last_d;    // byte being sent was flagged last
    logic            lvl_q, lvl_d;      // NRZI level, 1 = J
    logic            dp_q, dp_d;
    logic            dm_q, dm_d;
    logic            active_q, active_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic            bit_end;
    logic            stuff_due;
    logic            byte_end;
    logic            more_bytes;
    logic            in_serial;
    logic            fetch;
    logic            send;
    logic            send_bit;
    logic            drive_lvl;

    assign bit_end    = (cnt_q == CntMax);
    assign stuff_due  = (ones_q == 3'd6);
    assign byte_end   = (idx_q == 3'd7);
    assign in_serial  = (state_q == StSync) || (state_q == StData);
    // After SYNC a byte is always wanted; in DATA only if the current byte is not last.
    assign more_bytes = (state_q == StSync) || !last_q;

    // Fetch on the final cycle of the bit time before a new byte's first bit. When a
    // stuff bit is due it is sent first and idx stays at 7, so the fetch moves to the
    // end of that stuff bit.
    assign fetch         = in_serial && bit_end && !stuff_due && byte_end && more_bytes;
    assign tx_data_ready = fetch;

    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_end ? '0 : cnt_q + CntW'(1);
        idx_d     = idx_q;
        ones_d    = ones_q;
        shift_d   = shift_q;
        last_d    = last_q;
        lvl_d     = lvl_q;
        dp_d      = dp_q;
        dm_d      = dm_q;
        active_d  = active_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        send      = 1'b0;
        send_bit  = 1'b0;
        drive_lvl = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d    = '0;
                dp_d     = 1'b1;
                dm_d     = 1'b0;
                active_d = 1'b0;
                if (tx_start) begin
                    // NRZI restarts from J; SYNC bit 0 is a raw 0, so the line goes to K.
                    state_d  = StSync;
                    shift_d  = SyncPattern;
                    idx_d    = 3'd0;
                    ones_d   = 3'd0;
                    last_d   = 1'b0;
                    lvl_d    = 1'b0;
                    dp_d     = 1'b0;
                    dm_d     = 1'b1;
                    active_d = 1'b1;
                end
            end

            StSync, StData: begin
                if (bit_end) begin
                    if (stuff_due) begin
                        // Stuffed 0: toggles the line, consumes no data.
                        ones_d    = 3'd0;
                        lvl_d     = ~lvl_q;
                        drive_lvl = 1'b1;
                    end else if (byte_end) begin
                        if (more_bytes && tx_data_valid) begin
                            state_d  = StData;
                            shift_d  = tx_data;
                            last_d   = tx_last;
                            idx_d    = 3'd0;
                            send     = 1'b1;
                            send_bit = tx_data[0];
                        end else begin
                            // Normal end of packet, or underrun truncating it.
                            error_d = more_bytes;
                            state_d = StEopSe0;
                            idx_d   = 3'd0;
                            dp_d    = 1'b0;
                            dm_d    = 1'b0;
                        end
                    end else begin
                        shift_d  = {1'b0, shift_q[7:1]};
                        idx_d    = idx_q + 3'd1;
                        send     = 1'b1;
                        send_bit = shift_q[1];
                    end
                end
            end

            StEopSe0: begin
                if (bit_end) begin
                    if (idx_q == 3'd1) begin
                        state_d = StEopJ;
                        dp_d    = 1'b1;
                        dm_d    = 1'b0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            StEopJ: begin
                if (bit_end) begin
                    state_d  = StIdle;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                    lvl_d    = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // NRZI: a raw 0 toggles the level, a raw 1 holds it and extends the run of ones.
        if (send) begin
            drive_lvl = 1'b1;
            if (send_bit) begin
                ones_d = ones_q + 3'd1;
            end else begin
                ones_d = 3'd0;
                lvl_d  = ~lvl_q;
            end
        end

        if (drive_lvl) begin
            dp_d = lvl_d;
            dm_d = ~lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            ones_q   <= 3'd0;
            shift_q  <= 8'h00;
            last_q   <= 1'b0;
            lvl_q    <= 1'b1;
            dp_q     <= 1'b1;
            dm_q     <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ones_q   <= ones_d;
            shift_q  <= shift_d;
            last_q   <= last_d;
            lvl_q    <= lvl_d;
            dp_q     <= dp_d;
            dm_q     <= dm_d;
            active_q <= active_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign d_plus_out  = dp_q;
    assign d_minus_out = dm_q;
    assign tx_active   = active_q;
    assign tx_done     = done_q;
    assign tx_error    = error_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// ---------------------------------------------------------------------------
// tb_usb_tx_encoder
//
// Self-checking bench for usb_tx_encoder. A reference model builds the
// expected per-bit line symbols, fetch cycles, underrun pulse and packet
// length from the bit-level rules (SYNC + bytes, stuffing, NRZI, EOP);
// each scenario task drives a packet and compares the recorded activity.
// Cycle 0 is the first cycle the SYNC bit is on the line.
// ---------------------------------------------------------------------------
module tb_usb_tx_encoder;

    localparam int CPB = 8;
    localparam logic [1:0] SymJ   = 2'b10;
    localparam logic [1:0] SymK   = 2'b01;
    localparam logic [1:0] SymSe0 = 2'b00;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_data_ready;
    logic       d_plus_out;
    logic       d_minus_out;
    logic       tx_active;
    logic       tx_done;
    logic       tx_error;

    always #5 clk = ~clk;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_last       (tx_last),
        .tx_data_ready (tx_data_ready),
        .d_plus_out    (d_plus_out),
        .d_minus_out   (d_minus_out),
        .tx_active     (tx_active),
        .tx_done       (tx_done),
        .tx_error      (tx_error)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] pkt_q[$];
    logic [7:0] want_q[$];
    logic [1:0] exp_sym[$];
    int         exp_rdy[$];
    int         exp_err;
    int         exp_len;
    logic [1:0] got_sym[$];
    bit         got_act[$];
    int         got_rdy[$];
    int         got_err[$];
    int         got_done;
    int         got_xfers;

    // Reference model: raw bits -> stuffed bits -> NRZI symbols per bit time.
    task automatic build_model(input bit underrun);
        bit         raw[$];
        bit         tx[$];
        int         tx_of_raw[$];
        int         ones = 0;
        bit         lvl = 1'b1;
        logic [7:0] sync = 8'h80;
        exp_sym.delete();
        exp_rdy.delete();
        for (int i = 0; i < 8; i++) raw.push_back(sync[i]);
        foreach (pkt_q[k]) for (int i = 0; i < 8; i++) raw.push_back(pkt_q[k][i]);
        for (int r = 0; r < raw.size(); r++) begin
            tx_of_raw.push_back(tx.size());
            tx.push_back(raw[r]);
            if (raw[r]) ones++;
            else ones = 0;
            if (ones == 6) begin
                tx.push_back(1'b0);
                ones = 0;
            end
        end
        // Fetch ends the bit time just before each byte's first bit.
        foreach (pkt_q[k]) exp_rdy.push_back(tx_of_raw[8 + 8 * k] * CPB - 1);
        exp_err = -1;
        if (underrun) begin
            exp_rdy.push_back(tx.size() * CPB - 1);
            exp_err = tx.size() * CPB;
        end
        foreach (tx[i]) begin
            if (!tx[i]) lvl = ~lvl;
            exp_sym.push_back(lvl ? SymJ : SymK);
        end
        exp_sym.push_back(SymSe0);
        exp_sym.push_back(SymSe0);
        exp_sym.push_back(SymJ);
        exp_len = exp_sym.size() * CPB;
    endtask

    task automatic drive_bus(input int ptr, input bit underrun);
        tx_data_valid = (ptr < pkt_q.size());
        tx_data       = tx_data_valid ? pkt_q[ptr] : 8'($urandom);
        tx_last       = (ptr == pkt_q.size() - 1) && !underrun;
    endtask

    task automatic run_packet(input bit underrun, input int glitch_cyc, input string name);
        int  ptr = 0;
        bit  adv = 1'b0;
        bit  seen_done = 1'b0;
        int  bad_cyc = -1;
        bit  rdy_ok;
        int  lim;
        logic [1:0] e;
        bit  ea;
        build_model(underrun);
        got_sym.delete();
        got_act.delete();
        got_rdy.delete();
        got_err.delete();
        got_done  = -1;
        got_xfers = 0;
        @(posedge clk);
        #1;
        tx_start = 1'b1;
        drive_bus(ptr, underrun);
        for (int cyc = 0; cyc < exp_len + 200 && !seen_done; cyc++) begin
            @(posedge clk);
            #1;
            tx_start = (cyc == glitch_cyc);
            if (adv) begin
                ptr++;
                adv = 1'b0;
                drive_bus(ptr, underrun);
            end
            @(negedge clk);
            got_sym.push_back({d_plus_out, d_minus_out});
            got_act.push_back(tx_active);
            if (tx_data_ready) begin
                got_rdy.push_back(cyc);
                if (tx_data_valid) begin
                    adv = 1'b1;
                    got_xfers++;
                end
            end
            if (tx_error) got_err.push_back(cyc);
            if (tx_done) begin
                got_done  = cyc;
                seen_done = 1'b1;
            end
        end
        tx_start      = 1'b0;
        tx_data_valid = 1'b0;
        tx_last       = 1'b0;

        n_cmp++;
        if (got_done !== exp_len) begin
            n_bad++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, got_done, exp_len);
        end

        lim = (got_sym.size() < exp_len + 1) ? got_sym.size() : exp_len + 1;
        for (int c = 0; c < lim && bad_cyc < 0; c++) begin
            e  = (c < exp_len) ? exp_sym[c / CPB] : SymJ;
            ea = (c < exp_len);
            if (got_sym[c] !== e || got_act[c] !== ea) bad_cyc = c;
        end
        if (lim < exp_len + 1 && bad_cyc < 0) bad_cyc = lim;
        n_cmp++;
        if (bad_cyc >= 0) begin
            n_bad++;
            if (bad_cyc < got_sym.size())
                $display("FAIL %s line: cycle %0d got sym %b act %0d want sym %b act %0d",
                         name, bad_cyc, got_sym[bad_cyc], got_act[bad_cyc],
                         (bad_cyc < exp_len) ? exp_sym[bad_cyc / CPB] : SymJ,
                         bad_cyc < exp_len);
            else
                $display("FAIL %s line: trace ended at %0d want %0d cycles",
                         name, got_sym.size(), exp_len + 1);
        end

        rdy_ok = (got_rdy.size() == exp_rdy.size());
        if (rdy_ok) foreach (exp_rdy[i]) if (got_rdy[i] != exp_rdy[i]) rdy_ok = 1'b0;
        n_cmp++;
        if (!rdy_ok) begin
            n_bad++;
            $display("FAIL %s ready: got %0d strobes first %0d want %0d strobes first %0d",
                     name, got_rdy.size(), (got_rdy.size() > 0) ? got_rdy[0] : -1,
                     exp_rdy.size(), (exp_rdy.size() > 0) ? exp_rdy[0] : -1);
        end

        n_cmp++;
        if (exp_err < 0 ? (got_err.size() != 0)
                        : (got_err.size() != 1 || got_err[0] != exp_err)) begin
            n_bad++;
            $display("FAIL %s error: got %0d pulses first %0d want first %0d", name,
                     got_err.size(), (got_err.size() > 0) ? got_err[0] : -1, exp_err);
        end

        n_cmp++;
        if (got_xfers != pkt_q.size()) begin
            n_bad++;
            $display("FAIL %s transfers: got %0d want %0d", name, got_xfers, pkt_q.size());
        end

        @(negedge clk);
        n_cmp++;
        if ({tx_done, tx_active, d_plus_out, d_minus_out} !== 4'b0010) begin
            n_bad++;
            $display("FAIL %s post_done: got done %0d act %0d dp %0d dm %0d want 0 0 1 0",
                     name, tx_done, tx_active, d_plus_out, d_minus_out);
        end
    endtask

    // Independent receiver: NRZI decode + destuff of the recorded line at mid-bit.
    task automatic check_decode(input string name);
        logic [1:0] prev = SymJ;
        logic [1:0] s;
        int         ones = 0;
        bit         bits[$];
        logic [7:0] by;
        bit         ok;
        for (int b = 0; b * CPB + CPB / 2 < got_sym.size(); b++) begin
            s = got_sym[b * CPB + CPB / 2];
            if (s == SymSe0) break;
            if (ones == 6) begin
                ones = 0;
                prev = s;
                continue;
            end
            bits.push_back(s == prev);
            if (s == prev) ones++;
            else ones = 0;
            prev = s;
        end
        ok = (bits.size() == 8 * want_q.size());
        for (int k = 0; ok && k < want_q.size(); k++) begin
            for (int i = 0; i < 8; i++) by[i] = bits[8 * k + i];
            if (by !== want_q[k]) begin
                ok = 1'b0;
                $display("FAIL %s decode_byte%0d: got %h want %h", name, k, by, want_q[k]);
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s decode: got %0d bits want %0d", name, bits.size(),
                     8 * want_q.size());
        end
    endtask

    task automatic test_reset();
        n_rst    = 1'b0;
        tx_start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({d_plus_out, d_minus_out, tx_active, tx_data_ready, tx_done, tx_error}
            !== 6'b100000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 100000",
                     {d_plus_out, d_minus_out, tx_active, tx_data_ready, tx_done, tx_error});
        end
        tx_start = 1'b0;
        n_rst    = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({d_plus_out, d_minus_out, tx_active} !== 3'b100) begin
            n_bad++;
            $display("FAIL idle_line: got %b want 100", {d_plus_out, d_minus_out, tx_active});
        end
    endtask

    task automatic test_single_zero();
        pkt_q = '{8'h00};
        run_packet(1'b0, -1, "single_00");
        n_cmp++;
        if (got_done != 152 || got_rdy.size() != 1 || got_rdy[0] != 63) begin
            n_bad++;
            $display("FAIL single_00_fixed: got done %0d ready %0d want 152 63", got_done,
                     (got_rdy.size() > 0) ? got_rdy[0] : -1);
        end
    endtask

    task automatic test_single_ff();
        pkt_q = '{8'hFF};
        run_packet(1'b0, -1, "single_ff");
        n_cmp++;
        if (got_done != 160 || got_sym.size() < 160 || got_sym[13 * CPB + 4] !== SymJ
            || got_sym[12 * CPB + 4] !== SymK) begin
            n_bad++;
            $display("FAIL single_ff_stuff: got done %0d want 160 with stuffed J at bit 13",
                     got_done);
        end
    endtask

    task automatic test_back_to_back();
        pkt_q  = '{8'hA5, 8'h3C};
        want_q = '{8'h80, 8'hA5, 8'h3C};
        run_packet(1'b0, -1, "b2b");
        check_decode("b2b");
    endtask

    task automatic test_underrun();
        pkt_q.delete();
        run_packet(1'b1, -1, "underrun");
        n_cmp++;
        if (got_err.size() != 1 || got_err[0] != 64 || got_done != 88) begin
            n_bad++;
            $display("FAIL underrun_fixed: got err %0d done %0d want 64 88",
                     (got_err.size() > 0) ? got_err[0] : -1, got_done);
        end
    endtask

    task automatic test_reset_mid();
        bit bad_seen = 1'b0;
        pkt_q = '{8'h3C, 8'h55, 8'h0F};
        @(posedge clk);
        #1;
        tx_start      = 1'b1;
        tx_data       = 8'h3C;
        tx_data_valid = 1'b1;
        tx_last       = 1'b0;
        @(posedge clk);
        #1;
        tx_start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        n_rst = 1'b0;
        @(posedge clk);
        #1;
        n_rst         = 1'b1;
        tx_data_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({d_plus_out, d_minus_out, tx_active, tx_done} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_mid_line: got %b want 1000",
                     {d_plus_out, d_minus_out, tx_active, tx_done});
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_done || tx_active || tx_data_ready) bad_seen = 1'b1;
        end
        n_cmp++;
        if (bad_seen) begin
            n_bad++;
            $display("FAIL reset_mid_quiet: got activity after reset want none");
        end
        run_packet(1'b0, -1, "after_reset");
    endtask

    task automatic test_start_ignored();
        pkt_q  = '{8'hA5, 8'h3C};
        want_q = '{8'h80, 8'hA5, 8'h3C};
        run_packet(1'b0, 90, "start_in_data");
        check_decode("start_in_data");
    endtask

    task automatic test_random();
        int  n;
        bit  ur;
        for (int p = 0; p < 8; p++) begin
            ur = ($urandom_range(0, 3) == 0);
            n  = ur ? $urandom_range(0, 3) : $urandom_range(1, 4);
            pkt_q.delete();
            for (int k = 0; k < n; k++)
                pkt_q.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            run_packet(ur, -1, $sformatf("random%0d", p));
        end
    endtask

    initial begin
        test_reset();
        test_single_zero();
        test_single_ff();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
